// File: rtl/sphere_closest_hit_resolver_if.sv
// Hit-test stream bundle for the closest-hit resolver: ray start, hit beats and resolved result.
// master drives rays/beats and consumes results; slave is the resolver.
interface sphere_closest_hit_resolver_if #(
  parameter int T_WIDTH   = 32,
  parameter int PI_WIDTH  = 8,
  parameter int PAYLOAD_W = 64
);
  logic                 ray_start_valid;
  logic                 ray_start_ready;
  logic [PI_WIDTH-1:0]  ray_prim_count;
  logic [T_WIDTH-1:0]   ray_t_max;

  logic                 hit_valid;
  logic                 hit_ready;
  logic                 hit_bhit;
  logic [T_WIDTH-1:0]   hit_t;
  logic [PI_WIDTH-1:0]  hit_pi;
  logic [PAYLOAD_W-1:0] hit_payload;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_hit;
  logic [T_WIDTH-1:0]   out_t;
  logic [PI_WIDTH-1:0]  out_pi;
  logic [PAYLOAD_W-1:0] out_payload;

  modport master (
    output ray_start_valid, ray_prim_count, ray_t_max,
    output hit_valid, hit_bhit, hit_t, hit_pi, hit_payload,
    output out_ready,
    input  ray_start_ready, hit_ready,
    input  out_valid, out_hit, out_t, out_pi, out_payload
  );

  modport slave (
    input  ray_start_valid, ray_prim_count, ray_t_max,
    input  hit_valid, hit_bhit, hit_t, hit_pi, hit_payload,
    input  out_ready,
    output ray_start_ready, hit_ready,
    output out_valid, out_hit, out_t, out_pi, out_payload
  );
endinterface

// File: rtl/sphere_closest_hit_resolver.sv
// Reduces one ray's hit beats to the closest qualifying hit; result valid the cycle after the last
// beat (or after start when count=0), held until out_ready; ready lines decode from state only.
module sphere_closest_hit_resolver #(
  parameter int T_WIDTH   = 32,
  parameter int PI_WIDTH  = 8,
  parameter int PAYLOAD_W = 64,
  parameter int T_MIN     = 1
) (
  input logic                          clk,
  input logic                          reset,
  sphere_closest_hit_resolver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic signed [T_WIDTH-1:0] T_MIN_S = T_WIDTH'(T_MIN);

  state_t                     state;
  state_t                     state_nxt;
  logic [PI_WIDTH-1:0]        remaining;
  logic signed [T_WIDTH-1:0]  best_t;
  logic [PI_WIDTH-1:0]        best_pi;
  logic [PAYLOAD_W-1:0]       best_payload;
  logic                       found;

  logic start_fire;
  logic hit_fire;
  logic qualify;

  assign start_fire = bus.ray_start_valid && bus.ray_start_ready;
  assign hit_fire   = bus.hit_valid && bus.hit_ready;

  // Strict '<' against the running best keeps the earlier beat on a tie.
  assign qualify = bus.hit_bhit
                && ($signed(bus.hit_t) >= T_MIN_S)
                && ($signed(bus.hit_t) < best_t);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_fire) begin
          state_nxt = (bus.ray_prim_count == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (hit_fire && remaining == PI_WIDTH'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gating keeps ray_start_ready low for the whole reset window.
  always_comb begin
    bus.ray_start_ready = (state == IDLE) && !reset;
    bus.hit_ready       = (state == COLLECT);
    bus.out_valid       = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining    <= '0;
      best_t       <= '0;
      best_pi      <= '0;
      best_payload <= '0;
      found        <= 1'b0;
    end else if (start_fire) begin
      remaining    <= bus.ray_prim_count;
      best_t       <= $signed(bus.ray_t_max);
      best_pi      <= '0;
      best_payload <= '0;
      found        <= 1'b0;
    end else if (hit_fire) begin
      if (remaining != '0) begin
        remaining <= remaining - PI_WIDTH'(1);
      end
      if (qualify) begin
        best_t       <= $signed(bus.hit_t);
        best_pi      <= bus.hit_pi;
        best_payload <= bus.hit_payload;
        found        <= 1'b1;
      end
    end
  end

  assign bus.out_hit     = found;
  assign bus.out_t       = best_t;
  assign bus.out_pi      = best_pi;
  assign bus.out_payload = best_payload;

endmodule

// File: tb/tb_sphere_closest_hit_resolver.sv
// Randomised and directed bench for the closest-hit resolver against a per-ray selection model.
module tb_sphere_closest_hit_resolver;

  localparam int TW = 32;
  localparam int PW = 8;
  localparam int DW = 64;

  typedef struct {
    logic                 bhit;
    logic signed [TW-1:0] t;
    logic [PW-1:0]        pi;
    logic [DW-1:0]        payload;
  } beat_t;

  typedef struct {
    logic                 hit;
    logic signed [TW-1:0] t;
    logic [PW-1:0]        pi;
    logic [DW-1:0]        payload;
  } res_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    exp_rise = 0;
  int    ready_mode = 2;
  int    hold_cnt = 0;
  bit    was_vld = 1'b0;
  beat_t beats[$];
  res_t  exp_q[$];
  res_t  last;
  res_t  held;

  sphere_closest_hit_resolver_if #(.T_WIDTH(TW), .PI_WIDTH(PW), .PAYLOAD_W(DW)) bus();

  sphere_closest_hit_resolver #(
    .T_WIDTH(TW), .PI_WIDTH(PW), .PAYLOAD_W(DW), .T_MIN(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired waiting for DUT", nm);
  endtask

  function automatic void add(input logic b, input int t, input int pi, input logic [DW-1:0] p);
    beat_t x;
    x.bhit    = b;
    x.t       = TW'(t);
    x.pi      = PW'(pi);
    x.payload = p;
    beats.push_back(x);
  endfunction

  // Closest qualifying beat: smallest t in [1, t_max), first occurrence wins.
  function automatic res_t model(input int cnt, input int tmax);
    res_t r;
    int   sel;
    sel = -1;
    for (int i = 0; i < cnt; i++) begin
      if (beats[i].bhit && int'(beats[i].t) >= 1 && int'(beats[i].t) < tmax) begin
        if (sel < 0 || int'(beats[i].t) < int'(beats[sel].t)) sel = i;
      end
    end
    r.hit     = (sel >= 0);
    r.t       = (sel >= 0) ? beats[sel].t : TW'(tmax);
    r.pi      = (sel >= 0) ? beats[sel].pi : '0;
    r.payload = (sel >= 0) ? beats[sel].payload : '0;
    return r;
  endfunction

  // which: 0 = ray start, 1 = hit beat. Returns at posedge+1 after the transfer.
  task automatic wait_accept(input int which, output bit ok);
    int g;
    bit acc;
    g = 0;
    do begin
      @(negedge clk);
      acc = (which == 0) ? bus.ray_start_ready : bus.hit_ready;
      if (acc) exp_rise = cyc + 1;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 300);
    ok = acc;
  endtask

  task automatic do_ray(input int cnt, input int tmax, input int gap_pct);
    bit ok;
    int d0;
    int g;
    exp_q.push_back(model(cnt, tmax));
    d0 = done_cnt;
    bus.ray_prim_count  = PW'(cnt);
    bus.ray_t_max       = TW'(tmax);
    bus.ray_start_valid = 1'b1;
    wait_accept(0, ok);
    bus.ray_start_valid = 1'b0;
    if (!ok) fail_now("start_accept");
    for (int i = 0; i < cnt && ok; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        bus.hit_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.hit_valid   = 1'b1;
      bus.hit_bhit    = beats[i].bhit;
      bus.hit_t       = beats[i].t;
      bus.hit_pi      = beats[i].pi;
      bus.hit_payload = beats[i].payload;
      wait_accept(1, ok);
      if (!ok) fail_now("hit_accept");
    end
    if (cnt > 0) bus.hit_valid = 1'b0;
    g = 0;
    while (done_cnt == d0 && g < 500) begin
      @(negedge clk);
      if (cnt == 0) chk("held_beat_not_taken", 64'(bus.hit_ready), 64'd0);
      g++;
    end
    if (done_cnt == d0) begin
      fail_now("result_handoff");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_last(input string nm, input logic h, input int t, input int pi,
                          input logic [DW-1:0] p);
    chk({nm, "_hit"}, 64'(last.hit), 64'(h));
    chk({nm, "_t"}, 64'(last.t), 64'(TW'(t)));
    chk({nm, "_pi"}, 64'(last.pi), 64'(PW'(pi)));
    chk({nm, "_payload"}, last.payload, p);
  endtask

  // Result checker: content on rise, stability while stalled, no drop without out_ready.
  always @(negedge clk) begin
    if (reset) begin
      was_vld = 1'b0;
    end else if (bus.out_valid) begin
      if (!was_vld) begin
        chk("rise_latency", 64'(cyc), 64'(exp_rise));
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: out_valid=1 with no ray outstanding");
        end else begin
          chk("out_hit", 64'(bus.out_hit), 64'(exp_q[0].hit));
          chk("out_t", 64'(bus.out_t), 64'(exp_q[0].t));
          chk("out_pi", 64'(bus.out_pi), 64'(exp_q[0].pi));
          chk("out_payload", bus.out_payload, exp_q[0].payload);
        end
        held.hit     = bus.out_hit;
        held.t       = bus.out_t;
        held.pi      = bus.out_pi;
        held.payload = bus.out_payload;
      end else begin
        chk("hold_hit", 64'(bus.out_hit), 64'(held.hit));
        chk("hold_t", 64'(bus.out_t), 64'(held.t));
        chk("hold_pi", 64'(bus.out_pi), 64'(held.pi));
        chk("hold_payload", bus.out_payload, held.payload);
      end
      chk("hit_ready_in_done", 64'(bus.hit_ready), 64'd0);
      chk("start_ready_in_done", 64'(bus.ray_start_ready), 64'd0);
      if (bus.out_ready) begin
        last = held;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        done_cnt++;
        was_vld = 1'b0;
      end else begin
        was_vld = 1'b1;
      end
    end else begin
      if (was_vld) begin
        total++;
        bad++;
        $display("FAIL out_valid_dropped: got 0 expected 1");
      end
      was_vld = 1'b0;
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      hold_cnt = bus.out_valid ? hold_cnt + 1 : 0;
      case (ready_mode)
        0:       bus.out_ready = 1'($urandom_range(1));
        3:       bus.out_ready = (hold_cnt > 10);
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int tmax;
    int cnt;
    bus.ray_start_valid = 1'b0;
    bus.ray_prim_count  = '0;
    bus.ray_t_max       = '0;
    bus.hit_valid       = 1'b0;
    bus.hit_bhit        = 1'b0;
    bus.hit_t           = '0;
    bus.hit_pi          = '0;
    bus.hit_payload     = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_hit", 64'(bus.out_hit), 64'd0);
    chk("rst_out_t", 64'(bus.out_t), 64'd0);
    chk("rst_out_pi", 64'(bus.out_pi), 64'd0);
    chk("rst_out_payload", bus.out_payload, 64'd0);
    chk("rst_hit_ready", 64'(bus.hit_ready), 64'd0);
    chk("rst_start_ready", 64'(bus.ray_start_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_start_ready", 64'(bus.ray_start_ready), 64'd1);
    chk("idle_hit_ready", 64'(bus.hit_ready), 64'd0);
    @(posedge clk);
    #1;

    // Closest of three
    beats.delete();
    add(1, 5, 1, 64'h100); add(1, 2, 2, 64'h200); add(1, 7, 3, 64'h300);
    do_ray(3, 100, 0);
    chk_last("t1", 1'b1, 2, 2, 64'h200);

    // No intersections: far clip passes through
    beats.delete();
    add(0, 3, 7, 64'h11); add(0, 4, 8, 64'h22);
    do_ray(2, 100, 0);
    chk_last("t2", 1'b0, 100, 0, 64'h0);

    // Tie keeps the earlier beat
    beats.delete();
    add(1, 4, 5, 64'h5555); add(1, 4, 9, 64'h9999);
    do_ray(2, 100, 0);
    chk_last("t3", 1'b1, 4, 5, 64'h5555);

    // Bounds: t<1 and t>=t_max rejected
    beats.delete();
    add(1, -1, 1, 64'ha1); add(1, 0, 2, 64'ha2); add(1, 50, 3, 64'ha3); add(1, 49, 4, 64'ha4);
    do_ray(4, 50, 0);
    chk_last("t4a", 1'b1, 49, 4, 64'ha4);
    beats.delete();
    add(1, -1, 1, 64'ha1); add(1, 0, 2, 64'ha2); add(1, 50, 3, 64'ha3);
    do_ray(3, 50, 0);
    chk_last("t4b", 1'b0, 50, 0, 64'h0);

    // Empty ray with a beat already waiting; that beat belongs to the next ray
    bus.hit_valid   = 1'b1;
    bus.hit_bhit    = 1'b1;
    bus.hit_t       = TW'(9);
    bus.hit_pi      = PW'(6);
    bus.hit_payload = 64'h66;
    beats.delete();
    do_ray(0, 30, 0);
    chk_last("t5a", 1'b0, 30, 0, 64'h0);
    add(1, 9, 6, 64'h66);
    do_ray(1, 30, 0);
    chk_last("t5b", 1'b1, 9, 6, 64'h66);

    // Same eight beats, gap-free then with random gaps
    beats.delete();
    for (int i = 0; i < 8; i++) begin
      add(1'($urandom_range(1)), int'($urandom_range(60)) - 5, i + 1, {$urandom, $urandom});
    end
    do_ray(8, 40, 0);
    do_ray(8, 40, 60);

    // Random rays with random downstream stalls
    ready_mode = 0;
    for (int r = 0; r < 25; r++) begin
      cnt  = int'($urandom_range(10));
      tmax = 20 + int'($urandom_range(180));
      beats.delete();
      for (int i = 0; i < cnt; i++) begin
        if ($urandom_range(1) == 1)
          add(1'(int'($urandom_range(99)) < 75), int'($urandom_range(12)) - 2,
              int'($urandom_range(255)), {$urandom, $urandom});
        else
          add(1'(int'($urandom_range(99)) < 75), int'($urandom_range(tmax + 10)) - 5,
              int'($urandom_range(255)), {$urandom, $urandom});
      end
      do_ray(cnt, tmax, 30);
    end

    // Downstream stalls for 10 cycles while the result is held
    ready_mode = 3;
    beats.delete();
    add(1, 12, 3, 64'hc3); add(1, 6, 4, 64'hc4); add(0, 2, 5, 64'hc5);
    do_ray(3, 90, 0);
    chk_last("t6_stall", 1'b1, 6, 4, 64'hc4);
    ready_mode = 2;

    // Reset mid-COLLECT clears everything immediately
    beats.delete();
    add(1, 10, 1, 64'h1); add(1, 8, 2, 64'h2); add(1, 6, 3, 64'h3);
    bus.ray_prim_count  = PW'(5);
    bus.ray_t_max       = TW'(77);
    bus.ray_start_valid = 1'b1;
    wait_accept(0, ok);
    bus.ray_start_valid = 1'b0;
    if (!ok) fail_now("rst_ray_start");
    for (int i = 0; i < 2 && ok; i++) begin
      bus.hit_valid   = 1'b1;
      bus.hit_bhit    = beats[i].bhit;
      bus.hit_t       = beats[i].t;
      bus.hit_pi      = beats[i].pi;
      bus.hit_payload = beats[i].payload;
      wait_accept(1, ok);
      if (!ok) fail_now("rst_ray_beat");
    end
    bus.hit_t  = beats[2].t;
    bus.hit_pi = beats[2].pi;
    @(negedge clk);
    chk("mid_collect_hit_ready", 64'(bus.hit_ready), 64'd1);
    chk("mid_collect_best_t", 64'(bus.out_t), 64'd8);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_hit", 64'(bus.out_hit), 64'd0);
    chk("arst_out_t", 64'(bus.out_t), 64'd0);
    chk("arst_out_pi", 64'(bus.out_pi), 64'd0);
    chk("arst_out_payload", bus.out_payload, 64'd0);
    chk("arst_hit_ready", 64'(bus.hit_ready), 64'd0);
    chk("arst_start_ready", 64'(bus.ray_start_ready), 64'd0);
    bus.hit_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_start_ready", 64'(bus.ray_start_ready), 64'd1);
    chk("post_rst_hit_ready", 64'(bus.hit_ready), 64'd0);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    beats.delete();
    add(1, 3, 7, 64'h77);
    do_ray(1, 40, 0);
    chk_last("after_rst", 1'b1, 3, 7, 64'h77);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
